// File: rtl/mix_columns_seq.sv
// mix_columns_seq: column-serial AES MixColumns engine.
// Accepts one 128-bit state per valid/ready handshake and mixes one
// 32-bit column per clock using xtime logic only (no tables). A bypass
// bit latched at accept passes the state through unmixed with the same
// four-cycle latency. The result appears on a valid/ready output port.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         fsm;
  fsm_t         fsm_nxt;
  logic [1:0]   col_cnt;
  logic [127:0] work;
  logic [127:0] result;
  logic [127:0] result_nxt;
  logic         bypass;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply one column by the fixed MixColumns matrix {2,3,1,1} circulant.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    return {x0 ^ (x1 ^ a1) ^ a2 ^ a3,
            a0 ^ x1 ^ (x2 ^ a2) ^ a3,
            a0 ^ a1 ^ x2 ^ (x3 ^ a3),
            (x0 ^ a0) ^ a1 ^ a2 ^ x3};
  endfunction

  // Next-state logic and handshake outputs.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    fsm_nxt  = fsm;
    in_ready = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) fsm_nxt = BUSY;
      end
      BUSY: begin
        if (col_cnt == 2'd3) fsm_nxt = DONE;
      end
      DONE: begin
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Select the current column, mix it (or pass it through) and merge it
  // into a copy of the result register.
  always_comb begin
    col_in = 32'h0;
    case (col_cnt)
      2'd0: col_in = work[127:96];
      2'd1: col_in = work[95:64];
      2'd2: col_in = work[63:32];
      2'd3: col_in = work[31:0];
      default: col_in = 32'h0;
    endcase

    col_out = bypass ? col_in : mix_col(col_in);

    result_nxt = result;
    case (col_cnt)
      2'd0: result_nxt[127:96] = col_out;
      2'd1: result_nxt[95:64]  = col_out;
      2'd2: result_nxt[63:32]  = col_out;
      2'd3: result_nxt[31:0]   = col_out;
      default: result_nxt = result;
    endcase
  end

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // Datapath: capture on accept, one column per BUSY cycle, publish the
  // complete result only on the last column so state_out never shows
  // partially mixed data.
  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= 128'h0;
      result    <= 128'h0;
      bypass    <= 1'b0;
      col_cnt   <= 2'd0;
      state_out <= 128'h0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            work    <= state_in;
            bypass  <= bypass_in;
            col_cnt <= 2'd0;
          end
        end
        BUSY: begin
          result  <= result_nxt;
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            state_out <= result_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: self-checking bench for mix_columns_seq.
// The reference model multiplies each column by the (Inv)MixColumns
// matrix using a generic GF(2^8) shift-and-add multiplier.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         bypass_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int n_checks = 0;
  int n_fail   = 0;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .bypass_in (bypass_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  // Absolute watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inverse);
    logic [7:0]   coef[4];
    logic [7:0]   a[16];
    logic [7:0]   b;
    logic [127:0] r;
    r = 128'h0;
    if (inverse) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - row + 4) % 4], a[4*c+k]);
        r[127-8*(4*c+row) -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a state, wait (bounded) for in_ready, and pass the accept edge.
  // Afterwards the inputs are scrambled to show they are sampled only at accept.
  task automatic accept(input logic [127:0] s, input logic b);
    int n;
    n         = 0;
    state_in  = s;
    bypass_in = b;
    in_valid  = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("accept_ready", 128'(in_ready), 128'(1));
    step();
    in_valid  = 1'b0;
    bypass_in = ~b;
    state_in  = rand128();
  endtask

  // Count edges from accept until out_valid, bounded.
  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 128'(lat), 128'(4));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] fips_in;
    logic [127:0] fips_out;
    logic [127:0] xt_in;
    logic [127:0] xt_out;
    logic [127:0] sa;
    logic [127:0] sb;
    logic [127:0] sc;
    logic [127:0] exp_v;

    fips_in  = 128'hdb135345_f20a225c_01010101_2d26314c;
    fips_out = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    xt_in    = 128'hc6c6c6c6_d4d4d4d5_80808080_ffffffff;
    xt_out   = 128'hc6c6c6c6_d5d5d7d6_80808080_ffffffff;

    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    bypass_in = 1'b0;
    state_in  = rand128();

    // Reset held two cycles with in_valid asserted.
    step();
    check("rst_in_ready_1", 128'(in_ready), 128'(0));
    check("rst_out_valid_1", 128'(out_valid), 128'(0));
    check("rst_state_out", state_out, 128'h0);
    step();
    check("rst_in_ready_2", 128'(in_ready), 128'(0));
    check("rst_out_valid_2", 128'(out_valid), 128'(0));
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 vector.
    accept(fips_in, 1'b0);
    check("fips_busy_in_ready", 128'(in_ready), 128'(0));
    wait_out("fips");
    check("fips_const", state_out, fips_out);
    check("fips_model", state_out, mix_model(fips_in, 1'b0));
    handshake("fips");

    // xtime reduction vector.
    accept(xt_in, 1'b0);
    wait_out("xtime");
    check("xtime_const", state_out, xt_out);
    check("xtime_model", state_out, mix_model(xt_in, 1'b0));
    handshake("xtime");

    // Bypass keeps the state and the latency.
    accept(fips_in, 1'b1);
    wait_out("bypass");
    check("bypass_value", state_out, fips_in);
    handshake("bypass");

    // Backpressure with a second state waiting.
    sa = rand128();
    sb = rand128();
    accept(sa, 1'b0);
    wait_out("bp_a");
    exp_v     = mix_model(sa, 1'b0);
    state_in  = sb;
    bypass_in = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_stable", state_out, exp_v);
      check("bp_valid_held", 128'(out_valid), 128'(1));
      check("bp_in_ready_low", 128'(in_ready), 128'(0));
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_hs_valid_drop", 128'(out_valid), 128'(0));
    check("bp_idle_in_ready", 128'(in_ready), 128'(1));
    step();
    in_valid  = 1'b0;
    state_in  = rand128();
    bypass_in = 1'b1;
    check("bp_b_accepted", 128'(in_ready), 128'(0));
    wait_out("bp_b");
    check("bp_b_value", state_out, mix_model(sb, 1'b0));
    handshake("bp_b");

    // Reset pulsed at E2 abandons the transaction.
    sc = rand128();
    accept(sc, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("midrst_no_valid", 128'(out_valid), 128'(0));
      step();
    end
    sc = rand128();
    accept(sc, 1'b0);
    wait_out("midrst_next");
    check("midrst_next_value", state_out, mix_model(sc, 1'b0));
    handshake("midrst_next");

    // Random round-trip through the inverse model.
    for (int t = 0; t < 100; t++) begin
      int dly;
      sa = rand128();
      accept(sa, 1'b0);
      wait_out("rnd");
      exp_v = mix_model(sa, 1'b0);
      check("rnd_fwd", state_out, exp_v);
      check("rnd_roundtrip", mix_model(state_out, 1'b1), sa);
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        step();
        check("rnd_hold", state_out, exp_v);
      end
      handshake("rnd");
    end

    // Random bypass traffic.
    for (int t = 0; t < 10; t++) begin
      sa = rand128();
      accept(sa, 1'b1);
      wait_out("rnd_byp");
      check("rnd_byp_value", state_out, sa);
      handshake("rnd_byp");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
